// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing NREG byte registers; `define I2C_GLITCH_FILTER_EN adds a majority glitch filter
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NREG     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [8*NREG-1:0] regs_o,
    output logic              wr_strobe,
    output logic              busy
);

    localparam int PW = $clog2(NREG);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_f, sda_f, scl_d, sda_d;
    state_t        state;
    logic [3:0]    cnt;
    logic [7:0]    shreg;
    logic          rw, ack_bit;
    logic [PW-1:0] ptr;
    logic [7:0]    regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    // Majority of the current and two previous samples: a 1-clk pulse never wins the vote.
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_f = scl_filt;
    assign sda_f = sda_filt;
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, byte_done, shift_state;
    assign scl_rise    = scl_f & ~scl_d;
    assign scl_fall    = ~scl_f & scl_d;
    assign start_det   = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det    = scl_f & scl_d & ~sda_d & sda_f;
    assign byte_done   = (cnt == 4'd8);
    assign shift_state = (state == ADDR) || (state == PTR) || (state == WDATA) || (state == RDATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            shreg     <= 8'h00;
            rw        <= 1'b0;
            ack_bit   <= 1'b1;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < NREG; k++) regs[k] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state  <= ADDR;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
            end else begin
                // In RDATA the same shift exposes the next outgoing bit at shreg[7].
                if (shift_state && scl_rise && !byte_done) begin
                    shreg <= {shreg[6:0], sda_f};
                    cnt   <= cnt + 4'd1;
                end
                case (state)
                    IDLE: ;
                    ADDR: if (scl_fall && byte_done) begin
                        cnt <= 4'd0;
                        if (shreg[7:1] == DEV_ADDR) begin
                            state  <= ADDR_ACK;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                            rw     <= shreg[0];
                        end else begin
                            state  <= IDLE;
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (rw) begin
                            state  <= RDATA;
                            shreg  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                        end else begin
                            state  <= PTR;
                            sda_oe <= 1'b0;
                        end
                    end
                    PTR: if (scl_fall && byte_done) begin
                        ptr    <= shreg[PW-1:0];
                        cnt    <= 4'd0;
                        state  <= PTR_ACK;
                        sda_oe <= 1'b1;
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        state  <= WDATA;
                        sda_oe <= 1'b0;
                    end
                    WDATA: if (scl_fall && byte_done) begin
                        regs[ptr] <= shreg;
                        wr_strobe <= 1'b1;
                        ptr       <= ptr + PW'(1);
                        cnt       <= 4'd0;
                        state     <= WDATA_ACK;
                        sda_oe    <= 1'b1;
                    end
                    RDATA: if (scl_fall) begin
                        if (byte_done) begin
                            cnt    <= 4'd0;
                            state  <= RDATA_ACK;
                            sda_oe <= 1'b0;
                        end else begin
                            sda_oe <= ~shreg[7];
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) ack_bit <= sda_f;
                        if (scl_fall) begin
                            if (!ack_bit) begin
                                ptr    <= ptr + PW'(1);
                                shreg  <= regs[ptr + PW'(1)];
                                sda_oe <= ~regs[ptr + PW'(1)][7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_regs
        assign regs_o[8*k +: 8] = regs[k];
    end

endmodule
